alu_issue_decoder: RTL

Registered instruction-decode and issue stage for the single-cycle RISC-V core. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes each into the 5-bit `EXE_*_OP` ALU operation code, register indices, the sign-extended immediate and the operand-B select. Results are presented to the ALU side through a 2-entry buffered valid/ready output. It is the producer end of the ALUOp interface that the ALU consumes.

---
 rtl/alu_issue_decoder_pkg.sv | 68 ++++++
 rtl/alu_issue_decoder_alu_op_decode.sv | 133 +++++++++++++
 rtl/alu_issue_decoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_issue_decoder_pkg.sv
// alu_issue_decoder_pkg: shared constants for the RV32I decode/issue stage.
// Holds the ALU operation codes (EXE_*_OP), the RV32I major opcodes and the
// funct3 -> base ALU operation helper used by the decoder.
package alu_issue_decoder_pkg;

  localparam int ALU_OP_W = 5;

  typedef logic [ALU_OP_W-1:0] exe_op_t;

  // ALU operation codes consumed by the ALU select input
  localparam exe_op_t EXE_NOP_OP  = 5'd0;
  localparam exe_op_t EXE_ADD_OP  = 5'd1;
  localparam exe_op_t EXE_SUB_OP  = 5'd2;
  localparam exe_op_t EXE_SLL_OP  = 5'd3;
  localparam exe_op_t EXE_SLT_OP  = 5'd4;
  localparam exe_op_t EXE_SLTU_OP = 5'd5;
  localparam exe_op_t EXE_XOR_OP  = 5'd6;
  localparam exe_op_t EXE_SRL_OP  = 5'd7;
  localparam exe_op_t EXE_SRA_OP  = 5'd8;
  localparam exe_op_t EXE_OR_OP   = 5'd9;
  localparam exe_op_t EXE_AND_OP  = 5'd10;
  localparam exe_op_t EXE_LB_OP   = 5'd11;
  localparam exe_op_t EXE_LH_OP   = 5'd12;
  localparam exe_op_t EXE_LW_OP   = 5'd13;
  localparam exe_op_t EXE_LBU_OP  = 5'd14;
  localparam exe_op_t EXE_LHU_OP  = 5'd15;
  localparam exe_op_t EXE_SB_OP   = 5'd16;
  localparam exe_op_t EXE_SH_OP   = 5'd17;
  localparam exe_op_t EXE_SW_OP   = 5'd18;
  localparam exe_op_t EXE_BEQ_OP  = 5'd19;
  localparam exe_op_t EXE_BNE_OP  = 5'd20;
  localparam exe_op_t EXE_BLT_OP  = 5'd21;
  localparam exe_op_t EXE_BGE_OP  = 5'd22;
  localparam exe_op_t EXE_BLTU_OP = 5'd23;
  localparam exe_op_t EXE_BGEU_OP = 5'd24;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base ALU operation selected by funct3 for register and immediate ALU forms
  function automatic exe_op_t alu_base_op(input logic [2:0] funct3);
    exe_op_t op;
    case (funct3)
      3'b000:  op = EXE_ADD_OP;
      3'b001:  op = EXE_SLL_OP;
      3'b010:  op = EXE_SLT_OP;
      3'b011:  op = EXE_SLTU_OP;
      3'b100:  op = EXE_XOR_OP;
      3'b101:  op = EXE_SRL_OP;
      3'b110:  op = EXE_OR_OP;
      default: op = EXE_AND_OP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decoder_alu_op_decode.sv
// alu_op_decode: purely combinational RV32I word -> ALU operation, immediate
// and operand-B select. Optional macro ALU_DEC_ILLEGAL_EN drives the illegal
// flag; without it the flag is tied low and bad words still decode to NOP.
module alu_op_decode
  import alu_issue_decoder_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ALU_SELECT_SIZE = 5
) (
  input  logic [31:0]                instr,
  output logic [ALU_SELECT_SIZE-1:0] alu_op,
  output logic [XLEN-1:0]            imm,
  output logic                       b_sel_imm,
  output logic                       illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  exe_op_t     op_c;
  logic [31:0] imm_c;
  logic        bsel_c;
  logic        bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Decode opcode/funct fields; any unrecognised combination collapses to NOP
  always_comb begin
    op_c   = EXE_NOP_OP;
    imm_c  = '0;
    bsel_c = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE)                           op_c = alu_base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)   op_c = EXE_SUB_OP;
        else if (funct7 == F7_ALT && funct3 == 3'b101)   op_c = EXE_SRA_OP;
        else                                             bad  = 1'b1;
      end
      OPC_OP_IMM: begin
        bsel_c = 1'b1;
        op_c   = alu_base_op(funct3);
        imm_c  = imm_i;
        if (funct3 == 3'b001) begin
          imm_c = imm_sh;
          if (funct7 != F7_BASE) bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          imm_c = imm_sh;
          if (funct7 == F7_ALT)       op_c = EXE_SRA_OP;
          else if (funct7 != F7_BASE) bad  = 1'b1;
        end
      end
      OPC_LOAD: begin
        bsel_c = 1'b1;
        imm_c  = imm_i;
        case (funct3)
          3'b000:  op_c = EXE_LB_OP;
          3'b001:  op_c = EXE_LH_OP;
          3'b010:  op_c = EXE_LW_OP;
          3'b100:  op_c = EXE_LBU_OP;
          3'b101:  op_c = EXE_LHU_OP;
          default: bad  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bsel_c = 1'b1;
        imm_c  = imm_s;
        case (funct3)
          3'b000:  op_c = EXE_SB_OP;
          3'b001:  op_c = EXE_SH_OP;
          3'b010:  op_c = EXE_SW_OP;
          default: bad  = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        bsel_c = 1'b1;
        imm_c  = imm_b;
        case (funct3)
          3'b000:  op_c = EXE_BEQ_OP;
          3'b001:  op_c = EXE_BNE_OP;
          3'b100:  op_c = EXE_BLT_OP;
          3'b101:  op_c = EXE_BGE_OP;
          3'b110:  op_c = EXE_BLTU_OP;
          3'b111:  op_c = EXE_BGEU_OP;
          default: bad  = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        op_c   = EXE_ADD_OP;
        bsel_c = 1'b1;
        imm_c  = imm_u;
      end
      OPC_JAL: begin
        op_c   = EXE_ADD_OP;
        bsel_c = 1'b1;
        imm_c  = imm_j;
      end
      OPC_JALR: begin
        op_c   = EXE_ADD_OP;
        bsel_c = 1'b1;
        imm_c  = imm_i;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op_c   = EXE_NOP_OP;
      imm_c  = '0;
      bsel_c = 1'b0;
    end
  end

  assign alu_op    = ALU_SELECT_SIZE'(op_c);
  assign imm       = XLEN'($signed(imm_c));
  assign b_sel_imm = bsel_c;

`ifdef ALU_DEC_ILLEGAL_EN
  assign illegal = bad;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: registered RV32I decode/issue stage. Decodes each
// accepted word and queues the record in a 2-entry buffer that feeds the ALU
// side over valid/ready. in_ready is a register, so there is no combinational
// path from out_ready. Optional macro ALU_DEC_ILLEGAL_EN enables the illegal
// flag in the decoder.
module alu_issue_decoder
  import alu_issue_decoder_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ALU_SELECT_SIZE = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_SELECT_SIZE-1:0] alu_op,
  output logic [4:0]                 rd,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [XLEN-1:0]            imm,
  output logic                       b_sel_imm,
  output logic                       illegal
);

  logic [ALU_SELECT_SIZE-1:0] dec_op;
  logic [XLEN-1:0]            dec_imm;
  logic                       dec_bsel;
  logic                       dec_ill;

  logic [ALU_SELECT_SIZE-1:0] op_mem   [2];
  logic [4:0]                 rd_mem   [2];
  logic [4:0]                 rs1_mem  [2];
  logic [4:0]                 rs2_mem  [2];
  logic [XLEN-1:0]            imm_mem  [2];
  logic                       bsel_mem [2];
  logic                       ill_mem  [2];

  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_next;
  logic       ready_q;
  logic       push, pop;

  alu_op_decode #(
    .XLEN            (XLEN),
    .ALU_SELECT_SIZE (ALU_SELECT_SIZE)
  ) u_dec (
    .instr     (in_instr),
    .alu_op    (dec_op),
    .imm       (dec_imm),
    .b_sel_imm (dec_bsel),
    .illegal   (dec_ill)
  );

  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  // Occupancy after this edge's push/pop; simultaneous push and pop cancel
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (pop && !push) count_next = count - 2'd1;
  end

  // Buffer storage, pointers, count and registered ready; reset drops all entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        op_mem[i]   <= ALU_SELECT_SIZE'(EXE_NOP_OP);
        rd_mem[i]   <= '0;
        rs1_mem[i]  <= '0;
        rs2_mem[i]  <= '0;
        imm_mem[i]  <= '0;
        bsel_mem[i] <= 1'b0;
        ill_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        op_mem[wr_ptr]   <= dec_op;
        rd_mem[wr_ptr]   <= in_instr[11:7];
        rs1_mem[wr_ptr]  <= in_instr[19:15];
        rs2_mem[wr_ptr]  <= in_instr[24:20];
        imm_mem[wr_ptr]  <= dec_imm;
        bsel_mem[wr_ptr] <= dec_bsel;
        ill_mem[wr_ptr]  <= dec_ill;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  assign alu_op    = op_mem[rd_ptr];
  assign rd        = rd_mem[rd_ptr];
  assign rs1       = rs1_mem[rd_ptr];
  assign rs2       = rs2_mem[rd_ptr];
  assign imm       = imm_mem[rd_ptr];
  assign b_sel_imm = bsel_mem[rd_ptr];
  assign illegal   = ill_mem[rd_ptr];

endmodule
